// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the single-cycle RISC-V core.
//   XLEN          - datapath width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0), used as the IF/ID reset payload
//   fetch_state_t - fetch-stage state machine encoding
//   addr_legal()  - word-aligned and in-range check for instruction addresses
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } fetch_state_t;

   // The limit is widened by two bits so that 4*mem_depth cannot overflow and
   // any address that wrapped past 2^32 is still caught by the range test.
   function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                       input int unsigned     mem_depth);
      logic [XLEN+1:0] limit;
      limit = (XLEN+2)'(mem_depth) << 2;
      return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the program counter, drives the
// combinational imem address and captures each returned word with its PC in an
// IF/ID register handed to decode over a valid/ready handshake. Branch/jump
// redirects replace the PC; an illegal fetch or redirect address parks the
// stage in a sticky fault until reset.
//
// Ports:
//   clk                - rising-edge clock
//   rst_n              - asynchronous active-low reset
//   imem_addr_o        - current fetch PC, to imem
//   imem_instr_i       - instruction word at imem_addr_o (combinational)
//   redirect_valid_i   - taken branch/jump this cycle
//   redirect_target_i  - new fetch byte address
//   out_valid_o        - IF/ID register holds a valid instruction
//   out_ready_i        - decode accepts this cycle
//   out_pc_o           - PC of out_instr_o
//   out_instr_o        - fetched instruction
//   out_pc_plus4_o     - out_pc_o + 4
//   fault_o            - sticky fetch fault
//   fault_pc_o         - offending address
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_pc_o,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_plus4_o,
   output logic        fault_o,
   output logic [31:0] fault_pc_o
);

   fetch_state_t state_q, state_d;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_pc_plus4_q, out_pc_plus4_d;
   logic [XLEN-1:0] out_instr_q, out_instr_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;

   logic            load_req;
   logic            do_redirect;
   logic            do_load;
   logic            do_fault;
   logic [XLEN-1:0] fault_addr;
   logic [XLEN-1:0] fetch_pc_inc;

   assign fetch_pc_inc = fetch_pc_q + 32'd4;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: BOOT lasts exactly one cycle, FAULT is terminal.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT, RUN: state_d = do_fault ? FAULT : RUN;
         FAULT:     state_d = FAULT;
         default:   state_d = BOOT;
      endcase
   end

   // Control outputs. A redirect always outranks a load; the slot can be
   // refilled when it is empty or its occupant is being taken this cycle.
   always_comb begin
      load_req    = !out_valid_q || out_ready_i;
      do_redirect = 1'b0;
      do_load     = 1'b0;
      do_fault    = 1'b0;
      fault_addr  = '0;
      if (state_q != FAULT) begin
         if (redirect_valid_i) begin
            if (addr_legal(redirect_target_i, MEM_DEPTH)) begin
               do_redirect = 1'b1;
            end else begin
               do_fault   = 1'b1;
               fault_addr = redirect_target_i;
            end
         end else if (load_req) begin
            if (addr_legal(fetch_pc_q, MEM_DEPTH)) begin
               do_load = 1'b1;
            end else begin
               do_fault   = 1'b1;
               fault_addr = fetch_pc_q;
            end
         end
      end
   end

   // Datapath next-state: everything holds unless a control strobe fires.
   always_comb begin
      fetch_pc_d     = fetch_pc_q;
      out_valid_d    = out_valid_q;
      out_pc_d       = out_pc_q;
      out_pc_plus4_d = out_pc_plus4_q;
      out_instr_d    = out_instr_q;
      fault_d        = fault_q;
      fault_pc_d     = fault_pc_q;
      if (do_redirect) begin
         // The held instruction is wrong-path; drop it even if it is stalled.
         fetch_pc_d  = redirect_target_i;
         out_valid_d = 1'b0;
      end
      if (do_load) begin
         out_instr_d    = imem_instr_i;
         out_pc_d       = fetch_pc_q;
         out_pc_plus4_d = fetch_pc_inc;
         out_valid_d    = 1'b1;
         fetch_pc_d     = fetch_pc_inc;
      end
      if (do_fault) begin
         fault_d     = 1'b1;
         fault_pc_d  = fault_addr;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q     <= RESET_PC;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_pc_plus4_q <= 32'd4;
         out_instr_q    <= NOP_INSTR;
         fault_q        <= 1'b0;
         fault_pc_q     <= '0;
      end else begin
         fetch_pc_q     <= fetch_pc_d;
         out_valid_q    <= out_valid_d;
         out_pc_q       <= out_pc_d;
         out_pc_plus4_q <= out_pc_plus4_d;
         out_instr_q    <= out_instr_d;
         fault_q        <= fault_d;
         fault_pc_q     <= fault_pc_d;
      end
   end

   assign imem_addr_o    = fetch_pc_q;
   assign out_valid_o    = out_valid_q;
   assign out_pc_o       = out_pc_q;
   assign out_pc_plus4_o = out_pc_plus4_q;
   assign out_instr_o    = out_instr_q;
   assign fault_o        = fault_q;
   assign fault_pc_o     = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural imem feeds
// the DUT; expected PCs are queued as stimulus is driven and a monitor pops and
// compares every accepted IF/ID transfer. Direct checks cover reset values,
// stalls, redirects, faults and asynchronous reset.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;

   logic [31:0] mem [256];
   logic [31:0] exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .MEM_DEPTH (256)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_addr_o       (imem_addr),
      .imem_instr_i      (imem_instr),
      .redirect_valid_i  (redirect_valid),
      .redirect_target_i (redirect_target),
      .out_valid_o       (out_valid),
      .out_ready_i       (out_ready),
      .out_pc_o          (out_pc),
      .out_instr_o       (out_instr),
      .out_pc_plus4_o    (out_pc_plus4),
      .fault_o           (fault),
      .fault_pc_o        (fault_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_at(input logic [31:0] pc);
      return mem[pc[9:2]];
   endfunction

   // Scoreboard: every completed handshake must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_pc", out_pc, 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e);
            check("sb_instr", out_instr, mem_at(e));
            check("sb_pc_plus4", out_pc_plus4, e + 32'd4);
         end
      end
   end

   task automatic check_reset_values();
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_pc_plus4", out_pc_plus4, 32'h4);
      check("rst_instr", out_instr, 32'h0000_0013);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_fault_pc", fault_pc, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h0800_2083;
      mem[1]   = 32'h0840_2103;
      mem[2]   = 32'h0020_81B3;
      mem[3]   = 32'h0880_2223;
      mem[4]   = 32'h0000_0063;
      mem[255] = 32'h0000_006F;

      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      out_ready       = 1'b0;
      rst_n           = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_reset_values();

      // Straight-line fetch with decode always ready.
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h10);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      next_cycle();
      check("boot_first_valid", {31'b0, out_valid}, 32'd1);
      check("boot_first_pc", out_pc, 32'h0);
      repeat (4) next_cycle();
      check("stream_pc10", out_pc, 32'h10);

      // Redirect to 0 while 0x10 is being handed over: one bubble.
      redirect_valid  = 1'b1;
      redirect_target = 32'h0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      next_cycle();
      redirect_valid = 1'b0;
      check("redir_bubble_valid", {31'b0, out_valid}, 32'd0);
      check("redir_imem_addr", imem_addr, 32'h0);
      next_cycle();
      check("redir_target_valid", {31'b0, out_valid}, 32'd1);
      check("redir_target_pc", out_pc, 32'h0);
      next_cycle();
      check("pre_stall_pc", out_pc, 32'h4);

      // Stall three cycles with pc 4 held.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("stall_valid", {31'b0, out_valid}, 32'd1);
         check("stall_pc", out_pc, 32'h4);
         check("stall_instr", out_instr, 32'h0840_2103);
         check("stall_imem_addr", imem_addr, 32'h8);
      end
      out_ready = 1'b1;
      exp_q.push_back(32'h8);
      next_cycle();
      check("post_stall_pc", out_pc, 32'h8);

      // Misaligned redirect faults; later redirects are ignored.
      redirect_valid  = 1'b1;
      redirect_target = 32'h6;
      next_cycle();
      redirect_target = 32'h0;
      check("fault_set", {31'b0, fault}, 32'd1);
      check("fault_pc_misalign", fault_pc, 32'h6);
      check("fault_valid", {31'b0, out_valid}, 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      check("fault_sticky", {31'b0, fault}, 32'd1);
      check("fault_pc_hold", fault_pc, 32'h6);
      check("fault_valid_hold", {31'b0, out_valid}, 32'd0);
      check("fault_imem_hold", imem_addr, 32'hC);
      rst_n = 1'b0;
      #1;
      check("fault_clear", {31'b0, fault}, 32'd0);

      // Redirect in BOOT to the last word, then run off the end of memory.
      @(negedge clk);
      rst_n           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h3FC;
      next_cycle();
      redirect_valid = 1'b0;
      check("boot_redir_valid", {31'b0, out_valid}, 32'd0);
      check("boot_redir_addr", imem_addr, 32'h3FC);
      exp_q.push_back(32'h3FC);
      next_cycle();
      check("last_word_pc", out_pc, 32'h3FC);
      next_cycle();
      check("range_fault", {31'b0, fault}, 32'd1);
      check("range_fault_pc", fault_pc, 32'h400);
      check("range_fault_valid", {31'b0, out_valid}, 32'd0);
      check("range_fault_pc_hold", out_pc, 32'h3FC);
      rst_n = 1'b0;
      #1;
      check("range_fault_clear", {31'b0, fault}, 32'd0);

      // Restart, then reset asynchronously mid-stream.
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      repeat (3) next_cycle();
      check("restart_pc8", out_pc, 32'h8);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      repeat (3) next_cycle();
      out_ready = 1'b0;
      check("final_pc", out_pc, 32'h8);
      check("final_valid", {31'b0, out_valid}, 32'd1);
      repeat (2) next_cycle();
      check("sb_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core. Owns the program counter, drives the asynchronous instruction memory (`imem`) address, and registers each returned word with its PC into an IF/ID output register. The decode stage takes instructions through a valid/ready handshake. Redirects from branch/jump resolution are accepted, and illegal fetch addresses raise a sticky fault.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset; must be word-aligned.
- `MEM_DEPTH`, 256, `imem` depth in words; legal byte addresses are 0 to 4*MEM_DEPTH-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `imem_addr`  out  32  equals the `fetch_pc` register; wired to `imem.addr`
- `imem_instr`  in  32  from `imem.instr`; combinational read
- `redirect_valid`  in  1  taken branch/jump this cycle
- `redirect_target`  in  32  new fetch byte address
- `out_valid`  out  1  IF/ID register holds a valid instruction
- `out_ready`  in  1  decode accepts this cycle
- `out_pc`  out  32  PC of `out_instr`
- `out_instr`  out  32  fetched instruction
- `out_pc_plus4`  out  32  `out_pc` + 4, registered
- `fault`  out  1  sticky fetch fault
- `fault_pc`  out  32  offending address

## Operation
- State machine with three states:
  - BOOT: the first cycle after reset. `out_valid` is 0 and `fetch_pc` = `RESET_PC`. Moves to RUN on the next edge; the load rules below already apply in this cycle.
  - RUN: normal fetch.
  - FAULT: terminal. Only `rst_n` exits it.
- Load condition: `load = !out_valid || out_ready`. This is evaluated in BOOT and RUN, with no redirect, and only when `fetch_pc` is legal.
- On load:
  - `out_instr` <= `imem_instr`
  - `out_pc` <= `fetch_pc`
  - `out_pc_plus4` <= `fetch_pc` + 4
  - `out_valid` <= 1
  - `fetch_pc` <= `fetch_pc` + 4
- If not loading and not redirecting, all registers hold. This is the stall case.
- `redirect_valid` has priority over load:
  - `fetch_pc` <= `redirect_target`
  - `out_valid` <= 0, regardless of `out_ready`. The held instruction is wrong-path. A handshake completing in the same cycle still counts as accepted.
- Legality: an address is legal when bits [1:0] are 0 and the address is below 4*MEM_DEPTH. Arithmetic is unsigned 32-bit, and +4 wraps modulo 2^32; the range check catches any wrap.
- Fault entry:
  - Redirect to an illegal target: go to FAULT and set `fault_pc` = target.
  - A load attempted with an illegal `fetch_pc`: go to FAULT and set `fault_pc` = `fetch_pc`.
  - In both cases set `fault` = 1 and `out_valid` <= 0.
- In FAULT: `redirect_valid` and `out_ready` are ignored, and all outputs hold.

## Timing
- Reset values:
  - `imem_addr` = `RESET_PC`
  - `out_valid` = 0
  - `out_pc` = 0
  - `out_pc_plus4` = 4
  - `out_instr` = 32'h0000_0013 (NOP)
  - `fault` = 0
  - `fault_pc` = 0
  - state = BOOT
- Assertion of `rst_n` mid-operation clears all of the above immediately, without waiting for a clock edge.
- Fetch latency: an address driven in cycle N appears on `out_*` with `out_valid` = 1 in cycle N+1.
- Sustained throughput with `out_ready` held high: one instruction per cycle.
- Redirect in cycle N:
  - N+1: `imem_addr` = target, `out_valid` = 0.
  - N+2: target instruction is valid.
  - Cost is one bubble.
- `out_*` must stay stable while `out_valid && !out_ready`. The only exception is a redirect, which drops `out_valid`.
- A redirect in the BOOT cycle is honoured.
- Simultaneous redirect and stall: the redirect wins.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0013
  - enum `fetch_state_t` {BOOT, RUN, FAULT}
  - `XLEN` = 32
- The block is a single module with no sub-modules. `imem` is instantiated beside it at core level, not inside it.

## Test plan
Memory preload: `imem` word 0 = 08002083, 1 = 08402103, 2 = 002081B3, 3 = 08802223, 4 = 00000063.
- Reset, then hold `out_ready` = 1 → first cycle after BOOT shows `out_pc` 0 / 08002083, followed by pc 4 / 08402103, 8 / 002081B3, C / 08802223, 10 / 00000063 on consecutive cycles.
- Drive `out_ready` = 0 for 3 cycles while `out_pc` = 4 → `out_*` frozen at 4 / 08402103 and `imem_addr` held at 8. Restore `out_ready` = 1 → next output is pc 8.
- Assert `redirect_valid` with target 0x00000000 while `out_pc` = 0x10 → one cycle with `out_valid` = 0, then pc 0 / 08002083.
- Redirect to 0x00000006 → `fault` = 1, `fault_pc` = 6, and `out_valid` stays 0. A further redirect to 0 is ignored, and `rst_n` pulse clears `fault`.
- Redirect to 0x000003FC, then keep fetching → pc 3FC is delivered, then `fault` = 1 with `fault_pc` = 0x400.
- Assert `rst_n` = 0 asynchronously between clock edges mid-stream → outputs take reset values immediately, without waiting for a clock edge. Restart fetch from `RESET_PC`.
